multiplier_checker: RTL and testbench
=====================================

# multiplier_checker

Sequential shift-add reconstruct-and-compare unit: the inverse of the team's 8-bit/7-bit `divider`. Given a quotient, divisor and remainder, it computes quotient × divisor + remainder and flags whether the result equals the expected dividend and whether the remainder is below the divisor. It uses the same start/valid handshake and the same fixed 17-cycle latency as the divider. It sits downstream of the divider, as a built-in self-check, and also runs standalone in benches.

## Interface
- No parameters. Widths are fixed: quotient 8 bits, divisor 7, remainder 7, dividend 8, product 15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `start` in 1: one-cycle request pulse, sampled on the rising edge.
- `quotientin` in 8: multiplicand (unsigned).
- `divisorin` in 7: multiplier (unsigned; 0 is legal here).
- `remainderin` in 7: addend (unsigned).
- `dividendin` in 8: expected value for comparison.
- `product` out 15: quotientin×divisorin+remainderin.
- `match` out 1: product == zero-extended dividendin.
- `remok` out 1: remainderin < divisorin.
- `valid` out 1: product/match/remok are final.

## Operation
- States: IDLE, LOAD, RUN, WAIT, DONE. A 5-bit cycle counter `cnt` counts rising edges since the start edge.
- Edge E0 (start=1 sampled), from any state:
  - cnt←0, valid←0, product←0, match←0, remok←0, state←LOAD.
  - Operands are not sampled at E0; they are driven after start falls.
- E1 (LOAD):
  - Capture quotientin, divisorin, remainderin, dividendin into internal registers.
  - Accumulator (15 b) ← zero-extended remainder; state←RUN.
  - Inputs may change after E1 without effect.
- E2..E9 (RUN), eight iterations, quotient LSB first:
  - If the current quotient bit is 1, acc ← acc + (divisor << i), i = 0..7.
  - Max result is 255×127+126 = 32511; the 15-bit accumulator never overflows.
  - After E9, state←WAIT.
- E10..E16 (WAIT): idle padding; acc holds.
- E17: product←acc; match←(acc=={7'b0,dividend}); remok←(remainder<divisor); valid←1; state←DONE.
- DONE: outputs hold until the next start edge or reset.
- IDLE: entered only from reset; outputs all zero.
- Boundary behaviour:
  - **Start while busy (LOAD/RUN/WAIT):** aborts the current operation; the new E0 is that edge and latency restarts.
  - **Start high on consecutive edges:** every such edge is E0; timing counts from the last one.
  - **Divisor 0:** product = remainder; remok = 0.
  - **Reset low at any time:** immediately state←IDLE, cnt←0, all outputs 0. After release, nothing happens until a start edge.

## Timing
- Reset values: product=0, match=0, remok=0, valid=0.
- Latency: valid rises on the 17th rising edge after the start edge.
  - Matches the divider protocol: assert start for one cycle; at the following negedge drop start and apply operands; after 17 further negedges, valid=1 and results are correct.
  - One cycle early or late is an error.
- valid is 0 from E0 through E16 inclusive.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Operands must be stable at E1 only.

## Test plan
- **Basic:** quotient 13, divisor 9, remainder 5, dividend 122 → at E17 product=122, match=1, remok=1, valid=1. At E16, valid=0.
- **Maximum:** 255, 127, 126, dividend 255 → product=32511, match=0, remok=1.
- **Remainder violation and divisor 0:**
  - 3, 4, 4, dividend 16 → product=16, match=1, remok=0.
  - 7, 0, 5, dividend 5 → product=5, remok=0.
- **Restart mid-operation:** start at E0 with 10×10+0; second start at E6 with 2×3+1. Required: valid stays 0 until 17 edges after the second start, then product=7.
- **Reset mid-operation:** reset low at E8 → outputs 0 immediately. After release with no start for 30 cycles, valid remains 0.
- **Random loop:** 40 random operand sets using the divider's negedge protocol, dividend drawn independently and divisor ≠ 0. Each result is compared to a golden model: product, match and remok exact, valid=1 at E17.

Source files
------------

// File: rtl/multiplier_checker_if.sv
// -----------------------------------------------------------------------------
// multiplier_checker_if
// Groups the request/response signals of the multiplier_checker.
//   start        : one-cycle request pulse (master -> slave)
//   quotientin   : 8-bit multiplicand      (master -> slave)
//   divisorin    : 7-bit multiplier        (master -> slave)
//   remainderin  : 7-bit addend            (master -> slave)
//   dividendin   : 8-bit expected value    (master -> slave)
//   product      : 15-bit q*d+r            (slave -> master)
//   match        : product == dividend     (slave -> master)
//   remok        : remainder < divisor     (slave -> master)
//   valid        : results are final       (slave -> master)
// -----------------------------------------------------------------------------
interface multiplier_checker_if;
  logic        start;
  logic [7:0]  quotientin;
  logic [6:0]  divisorin;
  logic [6:0]  remainderin;
  logic [7:0]  dividendin;
  logic [14:0] product;
  logic        match;
  logic        remok;
  logic        valid;

  // Requester side: drives the operation, observes results.
  modport master (
    output start, quotientin, divisorin, remainderin, dividendin,
    input  product, match, remok, valid
  );

  // Checker side: receives the operation, returns results.
  modport slave (
    input  start, quotientin, divisorin, remainderin, dividendin,
    output product, match, remok, valid
  );
endinterface

// File: rtl/multiplier_checker.sv
// -----------------------------------------------------------------------------
// multiplier_checker
// Sequential shift-add reconstruct-and-compare unit. Computes
// quotient*divisor+remainder over eight iterations and compares the result
// against an expected dividend; also flags whether remainder < divisor.
// Fixed latency: valid rises on the 17th rising edge after the start edge.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low; clears all state
//   bus   : multiplier_checker_if.slave (start, operands in; results out)
// -----------------------------------------------------------------------------
module multiplier_checker (
  input  logic                 clk,
  input  logic                 reset,
  multiplier_checker_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // cnt holds k after edge Ek, so these are the pre-edge values at E9 and E17.
  localparam logic [4:0] LP_CNT_LAST_RUN  = 5'd8;
  localparam logic [4:0] LP_CNT_LAST_WAIT = 5'd16;

  state_t      r_state;
  state_t      w_state_next;

  logic [4:0]  r_cnt;

  // Captured operands.
  logic [6:0]  r_div;
  logic [6:0]  r_rem;
  logic [7:0]  r_dividend;

  // Shift-add datapath: quotient shifts right, divisor shifts left.
  logic [7:0]  r_quot_sh;
  logic [14:0] r_mcand_sh;
  logic [14:0] r_acc;

  // Registered outputs.
  logic [14:0] r_product;
  logic        r_match;
  logic        r_remok;
  logic        r_valid;

  logic        w_busy;
  logic        w_finish;
  logic [14:0] w_acc_next;
  logic        w_match;
  logic        w_remok;

  // Decode of the current phase.
  always_comb begin
    w_busy   = 1'b0;
    w_finish = 1'b0;
    if ((r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_WAIT)) begin
      w_busy = 1'b1;
    end else begin
      w_busy = 1'b0;
    end
    if ((r_state == ST_WAIT) && (r_cnt == LP_CNT_LAST_WAIT)) begin
      w_finish = 1'b1;
    end else begin
      w_finish = 1'b0;
    end
  end

  // One shift-add step and the final comparisons.
  always_comb begin
    w_acc_next = r_acc;
    if (r_quot_sh[0]) begin
      w_acc_next = r_acc + r_mcand_sh;
    end else begin
      w_acc_next = r_acc;
    end
    w_match = (r_acc == {7'd0, r_dividend});
    w_remok = (r_rem < r_div);
  end

  // Next-state logic; a start edge restarts from any state.
  always_comb begin
    w_state_next = r_state;
    if (bus.start) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_IDLE;
        ST_LOAD: w_state_next = ST_RUN;
        ST_RUN: begin
          if (r_cnt == LP_CNT_LAST_RUN) begin
            w_state_next = ST_WAIT;
          end else begin
            w_state_next = ST_RUN;
          end
        end
        ST_WAIT: begin
          if (r_cnt == LP_CNT_LAST_WAIT) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Cycle counter: edges since the start edge, frozen once finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 5'd0;
    end else if (bus.start) begin
      r_cnt <= 5'd0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 5'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Operand capture and shift-add iterations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div      <= 7'd0;
      r_rem      <= 7'd0;
      r_dividend <= 8'd0;
      r_quot_sh  <= 8'd0;
      r_mcand_sh <= 15'd0;
      r_acc      <= 15'd0;
    end else if (!bus.start) begin
      case (r_state)
        ST_LOAD: begin
          // Operands are valid only around E1; the accumulator starts at the addend.
          r_div      <= bus.divisorin;
          r_rem      <= bus.remainderin;
          r_dividend <= bus.dividendin;
          r_quot_sh  <= bus.quotientin;
          r_mcand_sh <= {8'd0, bus.divisorin};
          r_acc      <= {8'd0, bus.remainderin};
        end
        ST_RUN: begin
          r_acc      <= w_acc_next;
          r_quot_sh  <= {1'b0, r_quot_sh[7:1]};
          r_mcand_sh <= {r_mcand_sh[13:0], 1'b0};
        end
        default: begin
          r_acc      <= r_acc;
          r_quot_sh  <= r_quot_sh;
          r_mcand_sh <= r_mcand_sh;
        end
      endcase
    end else begin
      r_acc <= r_acc;
    end
  end

  // Result registers: cleared on start, loaded at E17, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_product <= 15'd0;
      r_match   <= 1'b0;
      r_remok   <= 1'b0;
      r_valid   <= 1'b0;
    end else if (bus.start) begin
      r_product <= 15'd0;
      r_match   <= 1'b0;
      r_remok   <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_finish) begin
      r_product <= r_acc;
      r_match   <= w_match;
      r_remok   <= w_remok;
      r_valid   <= 1'b1;
    end else begin
      r_product <= r_product;
      r_match   <= r_match;
      r_remok   <= r_remok;
      r_valid   <= r_valid;
    end
  end

  assign bus.product = r_product;
  assign bus.match   = r_match;
  assign bus.remok   = r_remok;
  assign bus.valid   = r_valid;

endmodule

// File: tb/tb_multiplier_checker.sv
// -----------------------------------------------------------------------------
// tb_multiplier_checker
// Self-checking bench for multiplier_checker. Expected results are computed
// arithmetically when an operation is launched and queued; they are popped
// and compared when valid is due.
// -----------------------------------------------------------------------------
module tb_multiplier_checker;

  logic clk;
  logic reset;

  multiplier_checker_if bus ();

  multiplier_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] p;
    logic        m;
    logic        ok;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  function automatic exp_t golden(input logic [7:0] q, input logic [6:0] d,
                                  input logic [6:0] r, input logic [7:0] dv);
    exp_t e;
    int   prod;
    prod = int'(q) * int'(d) + int'(r);
    e.p  = 15'(prod);
    e.m  = (prod == int'(dv));
    e.ok = (int'(r) < int'(d));
    return e;
  endfunction

  // Pulse start for one edge (already positioned after a negedge), then apply operands.
  task automatic launch(input logic [7:0] q, input logic [6:0] d,
                        input logic [6:0] r, input logic [7:0] dv, input string name);
    sb_q.push_back(golden(q, d, r, dv));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.quotientin  = q;
    bus.divisorin   = d;
    bus.remainderin = r;
    bus.dividendin  = dv;
    tests_run++;
    if (bus.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s e0_valid got %0b want 0", name, bus.valid);
    end
  endtask

  // Observe E1..E16 (valid low), scramble operands after E1, then check E17.
  task automatic finish_op(input string name);
    bit   early;
    exp_t e;
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.valid !== 1'b0) early = 1'b1;
      if (k == 1) begin
        bus.quotientin  = 8'($urandom);
        bus.divisorin   = 7'($urandom);
        bus.remainderin = 7'($urandom);
        bus.dividendin  = 8'($urandom);
      end
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL %s early_valid got 1 want 0 through E16", name);
    end
    @(negedge clk);
    tests_run++;
    if (bus.valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s valid_e17 got %0b want 1", name, bus.valid);
    end
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      if (bus.product !== e.p) begin
        tests_failed++;
        $display("FAIL %s product got %0d want %0d", name, bus.product, e.p);
      end
      tests_run++;
      if (bus.match !== e.m) begin
        tests_failed++;
        $display("FAIL %s match got %0b want %0b", name, bus.match, e.m);
      end
      tests_run++;
      if (bus.remok !== e.ok) begin
        tests_failed++;
        $display("FAIL %s remok got %0b want %0b", name, bus.remok, e.ok);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.quotientin = 8'd0; bus.divisorin = 7'd0;
    bus.remainderin = 7'd0; bus.dividendin = 8'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.product, bus.match, bus.remok, bus.valid} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got p=%0d m=%0b r=%0b v=%0b want all 0",
               bus.product, bus.match, bus.remok, bus.valid);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle valid got %0b want 0", bus.valid);
    end
  endtask

  task automatic test_basic();
    launch(8'd13, 7'd9, 7'd5, 8'd122, "basic");
    finish_op("basic");
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.valid !== 1'b1 || bus.product !== 15'd122 || bus.match !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_hold got v=%0b p=%0d m=%0b want 1 122 1",
               bus.valid, bus.product, bus.match);
    end
  endtask

  task automatic test_maximum();
    launch(8'd255, 7'd127, 7'd126, 8'd255, "maximum");
    finish_op("maximum");
  endtask

  task automatic test_remainder_div0();
    launch(8'd3, 7'd4, 7'd4, 8'd16, "rem_violation");
    finish_op("rem_violation");
    launch(8'd7, 7'd0, 7'd5, 8'd5, "divisor_zero");
    finish_op("divisor_zero");
  endtask

  task automatic test_restart();
    bit early;
    // First op is aborted, so its expectation is not queued.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.quotientin = 8'd10; bus.divisorin = 7'd10;
    bus.remainderin = 7'd0; bus.dividendin = 8'd100;
    early = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.valid !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL restart_first valid got 1 want 0");
    end
    launch(8'd2, 7'd3, 7'd1, 8'd7, "restart");
    finish_op("restart");
  endtask

  task automatic test_back_to_back();
    // Start held for three edges: latency counts from the last one.
    sb_q.push_back(golden(8'd20, 7'd6, 7'd2, 8'd122));
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    bus.quotientin = 8'd20; bus.divisorin = 7'd6;
    bus.remainderin = 7'd2; bus.dividendin = 8'd122;
    finish_op("start_held");
    // Immediate follow-on operation.
    launch(8'd1, 7'd1, 7'd0, 8'd9, "follow_on");
    finish_op("follow_on");
  endtask

  task automatic test_reset_mid();
    bit seen;
    // Async reset while DONE with nonzero outputs.
    launch(8'd50, 7'd5, 7'd3, 8'd253, "pre_reset");
    finish_op("pre_reset");
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.product, bus.match, bus.remok, bus.valid} !== 18'd0) begin
      tests_failed++;
      $display("FAIL async_reset got p=%0d v=%0b want 0 0", bus.product, bus.valid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // Reset at E8 of a running op; the op must never complete.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.quotientin = 8'd10; bus.divisorin = 7'd10;
    bus.remainderin = 7'd0; bus.dividendin = 8'd100;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.product, bus.match, bus.remok, bus.valid} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_e8 got p=%0d v=%0b want 0 0", bus.product, bus.valid);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL reset_no_start valid got 1 want 0 for 30 cycles");
    end
  endtask

  task automatic test_random();
    logic [7:0] q;
    logic [6:0] d;
    logic [6:0] r;
    logic [7:0] dv;
    for (int n = 0; n < 40; n++) begin
      q  = 8'($urandom_range(255, 0));
      d  = 7'($urandom_range(127, 1));
      r  = 7'($urandom_range(127, 0));
      dv = 8'($urandom_range(255, 0));
      launch(q, d, r, dv, "random");
      finish_op("random");
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_maximum();
    test_remainder_div0();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
